hhmm_level_sequencer: RTL

- Controller for one row of HHMM level cells. Each cell takes a 2-bit behaviour vector (BV) code and returns a state bit S0 and a termination bit T.
- The block drives the BV codes for N_CHILD cells:
  - initialises all cells;
  - walks them in order in search mode;
  - hands control to an external sub-level whenever the active cell's S0 fires;
  - reports completion when the last cell terminates.
- Sits between the parent level's start/done handshake and the level-cell array.

---
 rtl/hhmm_level_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/hhmm_level_sequencer.sv
// Sequencer driving BV codes to one row of HHMM level cells: init, ordered search, sub-level descent.
// Optional search watchdog enabled by defining HHMM_SEQ_WDOG_EN.
module hhmm_level_sequencer #(
  parameter int unsigned N_CHILD     = 4,
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned WDOG_MAX    = 255
) (
  input  logic                   CLK,
  input  logic                   INITn,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic [N_CHILD-1:0]     S0_VEC,
  input  logic [N_CHILD-1:0]     T_VEC,
  input  logic                   SUB_DONE,
  output logic [2*N_CHILD-1:0]   BV_BUS,
  output logic [3:0]             ACT_IDX,
  output logic                   SUB_START,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [7:0]             DESC_CNT,
  output logic                   TOUT
);

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DESC_W = 8;
  localparam int unsigned WDOG_W = 16;
  localparam int unsigned BV_W   = 2 * N_CHILD;

  localparam logic [1:0] BV_SLEEP  = 2'd0;
  localparam logic [1:0] BV_SEARCH = 2'd1;
  localparam logic [1:0] BV_SUB    = 2'd2;
  localparam logic [1:0] BV_INIT   = 2'd3;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_CHILD - 1);
  localparam logic [CNT_W-1:0]  INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [DESC_W-1:0] DESC_SAT  = {DESC_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SEARCH,
    ST_DESCEND,
    ST_FINISH
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   init_cnt, init_cnt_n;
  logic [IDX_W-1:0]   idx_n;
  logic [BV_W-1:0]    bv_n;
  logic [DESC_W-1:0]  desc_n;
  logic               sub_start_n, done_n, tout_n;
  logic               s0_sel, t_sel;

`ifdef HHMM_SEQ_WDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_MAX - 1);
  logic [WDOG_W-1:0]  wdog_cnt, wdog_n;

  always_ff @(posedge CLK) begin
    if (!INITn) wdog_cnt <= '0;
    else        wdog_cnt <= wdog_n;
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_W'(WDOG_MAX);
`endif

  // Only the active cell's S0/T bits are looked at
  always_comb begin
    s0_sel = 1'b0;
    t_sel  = 1'b0;
    for (int i = 0; i < N_CHILD; i++) begin
      if (ACT_IDX == IDX_W'(i)) begin
        s0_sel = S0_VEC[i];
        t_sel  = T_VEC[i];
      end
    end
  end

  always_comb begin
    state_n     = state;
    init_cnt_n  = init_cnt;
    idx_n       = ACT_IDX;
    desc_n      = DESC_CNT;
    sub_start_n = 1'b0;
`ifdef HHMM_SEQ_WDOG_EN
    tout_n      = TOUT;
    wdog_n      = wdog_cnt;
`else
    tout_n      = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (START) begin
          state_n    = ST_INIT;
          init_cnt_n = '0;
          idx_n      = '0;
          desc_n     = '0;
          tout_n     = 1'b0;
        end
      end
      ST_INIT: begin
        if (ABORT) begin
          state_n = ST_IDLE;
        end else if (init_cnt == INIT_LAST) begin
          state_n = ST_SEARCH;
          idx_n   = '0;
`ifdef HHMM_SEQ_WDOG_EN
          wdog_n  = '0;
`endif
        end else begin
          init_cnt_n = init_cnt + CNT_W'(1);
        end
      end
      ST_SEARCH: begin
        // T outranks S0 when both fire together
        if (ABORT) begin
          state_n = ST_IDLE;
        end else if (t_sel) begin
          if (ACT_IDX == LAST_IDX) begin
            state_n = ST_FINISH;
          end else begin
            idx_n = ACT_IDX + IDX_W'(1);
`ifdef HHMM_SEQ_WDOG_EN
            wdog_n = '0;
`endif
          end
        end else if (s0_sel) begin
          state_n     = ST_DESCEND;
          sub_start_n = 1'b1;
        end else begin
`ifdef HHMM_SEQ_WDOG_EN
          if (wdog_cnt == WDOG_LAST) begin
            tout_n  = 1'b1;
            state_n = ST_FINISH;
          end else begin
            wdog_n = wdog_cnt + WDOG_W'(1);
          end
`endif
        end
      end
      ST_DESCEND: begin
        if (ABORT) begin
          state_n = ST_IDLE;
        end else if (SUB_DONE) begin
          state_n = ST_SEARCH;
          if (DESC_CNT != DESC_SAT) desc_n = DESC_CNT + DESC_W'(1);
`ifdef HHMM_SEQ_WDOG_EN
          wdog_n = '0;
`endif
        end
      end
      ST_FINISH: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase

    // BV pattern is derived from the upcoming state so it appears registered with it
    bv_n = '0;
    for (int i = 0; i < N_CHILD; i++) begin
      bv_n[2*i +: 2] = BV_SLEEP;
      case (state_n)
        ST_INIT:    bv_n[2*i +: 2] = BV_INIT;
        ST_SEARCH:  if (idx_n == IDX_W'(i)) bv_n[2*i +: 2] = BV_SEARCH;
        ST_DESCEND: if (idx_n == IDX_W'(i)) bv_n[2*i +: 2] = BV_SUB;
        default:    bv_n[2*i +: 2] = BV_SLEEP;
      endcase
    end
    done_n = (state_n == ST_FINISH);
  end

  always_ff @(posedge CLK) begin
    if (!INITn) begin
      state     <= ST_IDLE;
      init_cnt  <= '0;
      BV_BUS    <= '0;
      ACT_IDX   <= '0;
      SUB_START <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      DESC_CNT  <= '0;
      TOUT      <= 1'b0;
    end else begin
      state     <= state_n;
      init_cnt  <= init_cnt_n;
      BV_BUS    <= bv_n;
      ACT_IDX   <= idx_n;
      SUB_START <= sub_start_n;
      BUSY      <= (state_n != ST_IDLE);
      DONE      <= done_n;
      DESC_CNT  <= desc_n;
      TOUT      <= tout_n;
    end
  end

endmodule
